// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter: round-robin arbiter that hands one requester's command and write stream downstream.
module dispatch_arbiter #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int InnerIFLengthWidth = 16
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [5:0]                    iR0Opcode,
  input  logic [4:0]                    iR0TargetID,
  input  logic [4:0]                    iR0SourceID,
  input  logic [AddressWidth-1:0]       iR0Address,
  input  logic [InnerIFLengthWidth-1:0] iR0Length,
  input  logic                          iR0CmdValid,
  output logic                          oR0CmdReady,
  input  logic [DataWidth-1:0]          iR0WriteData,
  input  logic                          iR0WriteValid,
  input  logic                          iR0WriteLast,
  output logic                          oR0WriteReady,
  input  logic [5:0]                    iR1Opcode,
  input  logic [4:0]                    iR1TargetID,
  input  logic [4:0]                    iR1SourceID,
  input  logic [AddressWidth-1:0]       iR1Address,
  input  logic [InnerIFLengthWidth-1:0] iR1Length,
  input  logic                          iR1CmdValid,
  output logic                          oR1CmdReady,
  input  logic [DataWidth-1:0]          iR1WriteData,
  input  logic                          iR1WriteValid,
  input  logic                          iR1WriteLast,
  output logic                          oR1WriteReady,
  output logic [5:0]                    oDstOpcode,
  output logic [4:0]                    oDstTargetID,
  output logic [4:0]                    oDstSourceID,
  output logic [AddressWidth-1:0]       oDstAddress,
  output logic [InnerIFLengthWidth-1:0] oDstLength,
  output logic                          oDstCmdValid,
  input  logic                          iDstCmdReady,
  output logic [DataWidth-1:0]          oDstWriteData,
  output logic                          oDstWriteValid,
  output logic                          oDstWriteLast,
  input  logic                          iDstWriteReady,
  output logic [1:0]                    oGrant
);
  typedef enum logic [1:0] {Idle, Cmd, Trf} tState;
  tState state, nextState;
  logic prio, owner, sel, grant, ownerValid, ownerLast, finalBeat, inTrf;
  // prio/sel: 0 selects R0, 1 selects R1
  assign sel = prio ? iR1CmdValid : ~iR0CmdValid;
  assign grant = (state == Idle) && (iR0CmdValid || iR1CmdValid) && iReset;
  assign inTrf = (state == Trf);
  assign ownerValid = owner ? iR1WriteValid : iR0WriteValid;
  assign ownerLast = owner ? iR1WriteLast : iR0WriteLast;
  assign finalBeat = inTrf && ownerValid && ownerLast && iDstWriteReady;
  assign oR0CmdReady = grant && !sel;
  assign oR1CmdReady = grant && sel;
  assign oDstCmdValid = (state == Cmd);
  assign oDstWriteData = owner ? iR1WriteData : iR0WriteData;
  assign oDstWriteValid = inTrf && ownerValid;
  assign oDstWriteLast = inTrf && ownerLast;
  assign oR0WriteReady = inTrf && !owner && iDstWriteReady;
  assign oR1WriteReady = inTrf && owner && iDstWriteReady;
  assign oGrant = (state == Idle) ? 2'b00 : {owner, ~owner};
  always_comb begin
    nextState = state;
    nextState = (state == Idle) ? (grant ? Cmd : Idle)
              : (state == Cmd)  ? (iDstCmdReady ? ((oDstLength == '0) ? Idle : Trf) : Cmd)
              : (finalBeat ? Idle : Trf);
  end
  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) state <= Idle;
    else state <= nextState;
  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) begin
      prio <= 1'b0;
      owner <= 1'b0;
      oDstOpcode <= '0;
      oDstTargetID <= '0;
      oDstSourceID <= '0;
      oDstAddress <= '0;
      oDstLength <= '0;
    end else if (grant) begin
      prio <= ~sel;
      owner <= sel;
      oDstOpcode <= sel ? iR1Opcode : iR0Opcode;
      oDstTargetID <= sel ? iR1TargetID : iR0TargetID;
      oDstSourceID <= sel ? iR1SourceID : iR0SourceID;
      oDstAddress <= sel ? iR1Address : iR0Address;
      oDstLength <= sel ? iR1Length : iR0Length;
    end
endmodule

// File: tb/tb_dispatch_arbiter.sv
// tb_dispatch_arbiter: directed checks of arbitration, command latency, write routing and async reset.
module tb_dispatch_arbiter;
  logic iClock, iReset;
  logic [5:0] iR0Opcode, iR1Opcode, oDstOpcode;
  logic [4:0] iR0TargetID, iR0SourceID, iR1TargetID, iR1SourceID, oDstTargetID, oDstSourceID;
  logic [31:0] iR0Address, iR1Address, oDstAddress;
  logic [15:0] iR0Length, iR1Length, oDstLength;
  logic iR0CmdValid, iR1CmdValid, oR0CmdReady, oR1CmdReady;
  logic [31:0] iR0WriteData, iR1WriteData, oDstWriteData;
  logic iR0WriteValid, iR0WriteLast, oR0WriteReady, iR1WriteValid, iR1WriteLast, oR1WriteReady;
  logic oDstCmdValid, iDstCmdReady, oDstWriteValid, oDstWriteLast, iDstWriteReady;
  logic [1:0] oGrant;
  int passCount = 0, checkCount = 0, k;
  logic rdy;

  dispatch_arbiter dut (
    .iClock(iClock), .iReset(iReset),
    .iR0Opcode(iR0Opcode), .iR0TargetID(iR0TargetID), .iR0SourceID(iR0SourceID),
    .iR0Address(iR0Address), .iR0Length(iR0Length), .iR0CmdValid(iR0CmdValid), .oR0CmdReady(oR0CmdReady),
    .iR0WriteData(iR0WriteData), .iR0WriteValid(iR0WriteValid), .iR0WriteLast(iR0WriteLast), .oR0WriteReady(oR0WriteReady),
    .iR1Opcode(iR1Opcode), .iR1TargetID(iR1TargetID), .iR1SourceID(iR1SourceID),
    .iR1Address(iR1Address), .iR1Length(iR1Length), .iR1CmdValid(iR1CmdValid), .oR1CmdReady(oR1CmdReady),
    .iR1WriteData(iR1WriteData), .iR1WriteValid(iR1WriteValid), .iR1WriteLast(iR1WriteLast), .oR1WriteReady(oR1WriteReady),
    .oDstOpcode(oDstOpcode), .oDstTargetID(oDstTargetID), .oDstSourceID(oDstSourceID),
    .oDstAddress(oDstAddress), .oDstLength(oDstLength), .oDstCmdValid(oDstCmdValid), .iDstCmdReady(iDstCmdReady),
    .oDstWriteData(oDstWriteData), .oDstWriteValid(oDstWriteValid), .oDstWriteLast(oDstWriteLast),
    .iDstWriteReady(iDstWriteReady), .oGrant(oGrant)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    iReset = 1'b0;
    {iR0Opcode, iR0TargetID, iR0SourceID, iR0Address, iR0Length, iR0CmdValid} = '0;
    {iR1Opcode, iR1TargetID, iR1SourceID, iR1Address, iR1Length, iR1CmdValid} = '0;
    {iR0WriteData, iR0WriteValid, iR0WriteLast, iR1WriteData, iR1WriteValid, iR1WriteLast} = '0;
    iDstCmdReady = 1'b0;
    iDstWriteReady = 1'b0;
    #2;
    iR0CmdValid = 1'b1;
    iR0WriteValid = 1'b1;
    #1;
    check("rstGrant", oGrant, 2'b00);
    check("rstCmdValid", oDstCmdValid, 0);
    check("rstAddress", oDstAddress, 0);
    check("rstCmdReady", oR0CmdReady, 0);
    check("rstWriteValid", oDstWriteValid, 0);
    @(negedge iClock);
    iReset = 1'b1;
    iR0CmdValid = 1'b0;
    iR0WriteValid = 1'b0;
    // both valid after reset: R0 wins
    @(negedge iClock);
    iR0Opcode = 6'd2; iR0Address = 32'h100; iR0Length = 16'd0; iR0TargetID = 5'd3; iR0CmdValid = 1'b1;
    iR1Opcode = 6'b000001; iR1Address = 32'h0000_1234; iR1Length = 16'd0; iR1SourceID = 5'd9; iR1CmdValid = 1'b1;
    #1;
    check("bothR0Ready", oR0CmdReady, 1);
    check("bothR1Ready", oR1CmdReady, 0);
    check("idleGrant", oGrant, 2'b00);
    @(negedge iClock);
    iR0CmdValid = 1'b0;
    #1;
    check("cmd0Valid", oDstCmdValid, 1);
    check("cmd0Addr", oDstAddress, 32'h100);
    check("cmd0Op", oDstOpcode, 6'd2);
    check("cmd0Target", oDstTargetID, 5'd3);
    check("cmd0Grant", oGrant, 2'b01);
    check("cmd0NoReady", {oR0CmdReady, oR1CmdReady}, 2'b00);
    iDstCmdReady = 1'b1;
    @(negedge iClock);
    iR0CmdValid = 1'b1;
    #1;
    check("altR1Ready", oR1CmdReady, 1);
    check("altR0Ready", oR0CmdReady, 0);
    check("len0Idle", oDstCmdValid, 0);
    @(negedge iClock);
    iR1CmdValid = 1'b0;
    iR1WriteValid = 1'b1;
    iR1WriteData = 32'hDEAD;
    iR0Opcode = 6'd4; iR0Address = 32'hA000; iR0Length = 16'd4;
    #1;
    check("cmd1Op", oDstOpcode, 6'b000001);
    check("cmd1Addr", oDstAddress, 32'h1234);
    check("cmd1Len", oDstLength, 0);
    check("cmd1Source", oDstSourceID, 5'd9);
    check("cmd1Grant", oGrant, 2'b10);
    check("cmd1NoBeat", oDstWriteValid, 0);
    @(negedge iClock);
    iDstCmdReady = 1'b0;
    #1;
    check("len0BackIdle", oGrant, 2'b00);
    check("len0NoBeat", oDstWriteValid, 0);
    check("r0AfterR1", oR0CmdReady, 1);
    // hold iDstCmdReady low while inputs churn
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock);
      iR0CmdValid = 1'b0;
      iR0Address = $urandom;
      iR1Address = $urandom;
      iR0Length = 16'(i + 7);
      #1;
      check("holdAddr", oDstAddress, 32'hA000);
      check("holdLen", oDstLength, 16'd4);
      check("holdValid", oDstCmdValid, 1);
    end
    @(negedge iClock);
    iDstCmdReady = 1'b1;
    #1;
    check("stillCmd", oDstCmdValid, 1);
    k = 0;
    rdy = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge iClock);
      iR0WriteData = 32'hA0 + 32'(k);
      iR0WriteValid = 1'b1;
      iR0WriteLast = (k == 3);
      iDstWriteReady = rdy;
      if (k == 3) iR1CmdValid = 1'b1;
      #1;
      check("trfCmdValid", oDstCmdValid, 0);
      check("trfGrant", oGrant, 2'b01);
      check("beatData", oDstWriteData, 32'hA0 + 32'(k));
      check("beatValid", oDstWriteValid, 1);
      check("beatLast", oDstWriteLast, k == 3);
      check("r0WriteReady", oR0WriteReady, rdy);
      check("r1WriteReady", oR1WriteReady, 0);
      if (k == 3) check("noGrantOnLast", oR1CmdReady, 0);
      if (rdy) k++;
      rdy = ~rdy;
    end
    check("beatsDone", k, 4);
    @(negedge iClock);
    iR1Opcode = 6'd3; iR1Address = 32'hB000; iR1Length = 16'd4;
    #1;
    check("postTrfGrant", oGrant, 2'b00);
    check("postTrfNoBeat", oDstWriteValid, 0);
    check("postTrfReady", oR0WriteReady, 0);
    check("r1NextReady", oR1CmdReady, 1);
    @(negedge iClock);
    iR1CmdValid = 1'b0;
    iR0WriteValid = 1'b0;
    #1;
    check("cmd2Addr", oDstAddress, 32'hB000);
    check("cmd2Grant", oGrant, 2'b10);
    for (int b = 0; b < 2; b++) begin
      @(negedge iClock);
      iR1WriteData = 32'hB0 + 32'(b);
      iR1WriteValid = 1'b1;
      iR1WriteLast = 1'b0;
      iDstWriteReady = 1'b1;
      #1;
      check("r1BeatData", oDstWriteData, 32'hB0 + 32'(b));
      check("r1BeatReady", oR1WriteReady, 1);
      check("r1OtherReady", oR0WriteReady, 0);
    end
    // async reset mid-transfer
    @(negedge iClock);
    iR1WriteData = 32'hB2;
    iReset = 1'b0;
    #1;
    check("arstCmdValid", oDstCmdValid, 0);
    check("arstWriteValid", oDstWriteValid, 0);
    check("arstGrant", oGrant, 2'b00);
    check("arstAddr", oDstAddress, 0);
    check("arstWriteReady", oR1WriteReady, 0);
    @(negedge iClock);
    iReset = 1'b1;
    iR1WriteValid = 1'b0;
    iR1CmdValid = 1'b1;
    #1;
    check("relGrant", oGrant, 2'b00);
    check("relR1Alone", oR1CmdReady, 1);
    iR0CmdValid = 1'b1;
    #1;
    check("relPrioR0", oR0CmdReady, 1);
    check("relPrioR1", oR1CmdReady, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/dispatch_arbiter.md
DISPATCH_ARBITER -- requirements
Module: dispatch_arbiter

Interface
REQ-001 SHALL have parameter AddressWidth, default 32, command address width.
REQ-002 SHALL have parameter DataWidth, default 32, write-data width.
REQ-003 SHALL have parameter InnerIFLengthWidth, default 16, command length width.
REQ-004 SHALL have port iClock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port iReset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have, for n in {0,1}, ports iR<n>Opcode in 6, iR<n>TargetID in 5, iR<n>SourceID in 5, iR<n>Address in AddressWidth, iR<n>Length in InnerIFLengthWidth: requester n command fields.
REQ-007 SHALL have, for n in {0,1}, ports iR<n>CmdValid in 1 and oR<n>CmdReady out 1: requester n command handshake.
REQ-008 SHALL have, for n in {0,1}, ports iR<n>WriteData in DataWidth, iR<n>WriteValid in 1, iR<n>WriteLast in 1, oR<n>WriteReady out 1: requester n write stream.
REQ-009 SHALL have ports oDstOpcode out 6, oDstTargetID out 5, oDstSourceID out 5, oDstAddress out AddressWidth, oDstLength out InnerIFLengthWidth, oDstCmdValid out 1, iDstCmdReady in 1: downstream command toward the scramble stage.
REQ-010 SHALL have ports oDstWriteData out DataWidth, oDstWriteValid out 1, oDstWriteLast out 1, iDstWriteReady in 1: downstream write stream.
REQ-011 SHALL have port oGrant, output, 2, one-hot owner of the current transaction (00 when Idle).

Function
REQ-012 SHALL implement states Idle, Cmd, Trf.
REQ-013 In Idle, when at least one iR<n>CmdValid is high, SHALL grant exactly one requester: the requester holding round-robin priority if it is valid, otherwise the other requester.
REQ-014 In Idle, oR<n>CmdReady SHALL be high combinationally only for the requester selected by REQ-013; both are low in Cmd and Trf.
REQ-015 On the grant cycle SHALL register the granted requester's opcode, target ID, source ID, address and length, and SHALL move to Cmd on the next edge.
REQ-016 SHALL drive oDstCmdValid high in Cmd and low in every other state; the registered command appears on the oDst* command ports one cycle after the grant (latency 1).
REQ-017 oDst* command fields SHALL stay stable while in Cmd, regardless of iR<n> activity.
REQ-018 In Cmd with iDstCmdReady high: registered length 0 -> Idle; otherwise -> Trf. Without iDstCmdReady SHALL remain in Cmd.
REQ-019 In Trf SHALL route the owner's stream combinationally: oDstWriteData/Valid/Last = owner's iR<n>WriteData/Valid/Last; owner's oR<n>WriteReady = iDstWriteReady.
REQ-020 Non-owner oR<n>WriteReady SHALL be 0 at all times; outside Trf oDstWriteValid and both oR<n>WriteReady SHALL be 0.
REQ-021 In Trf, a beat with owner WriteValid, WriteLast and iDstWriteReady all high SHALL be the final beat; the state SHALL return to Idle on that edge.
REQ-022 Round-robin priority SHALL pass to the non-granted requester on every grant; two continuously valid requesters SHALL alternate R0, R1, R0, ...
REQ-023 A requester de-asserting CmdValid while not granted SHALL lose nothing; no command is captured without its CmdValid/CmdReady handshake.
REQ-024 The earliest new grant SHALL be in the Idle cycle after the return to Idle; no back-to-back grant is made in the same cycle as a final beat.
REQ-025 oGrant SHALL be one-hot for the owner in Cmd and Trf and 00 in Idle.

Reset
REQ-026 With iReset low, SHALL immediately, without a clock edge, force state to Idle, priority to R0, oGrant 00, all registered command fields 0, and oDstCmdValid 0.
REQ-027 Reset asserted in Cmd or Trf SHALL abandon the transaction; after release SHALL start in Idle with no residual grant.
REQ-028 oR<n>CmdReady, oDstWriteValid and oR<n>WriteReady SHALL all be 0 while reset is asserted.

Verification
REQ-029 After reset, R0 and R1 valid in the same cycle -> R0 granted (oR0CmdReady=1, oR1CmdReady=0); the next grant goes to R1.
REQ-030 R1 command, Length=0, opcode 6'b000001, address 32'h0000_1234 -> oDstCmdValid high one cycle later with the same fields; iDstCmdReady=1 -> Idle; no write beats forwarded.
REQ-031 R0 command, Length=4, 4 beats 32'hA0..A3 with last on A3, iDstWriteReady toggling 1,0,1,... -> all 4 beats forwarded in order; oR1WriteReady stays 0; Idle after the A3 handshake.
REQ-032 iDstCmdReady held low 5 cycles in Cmd -> oDst* fields unchanged while R0/R1 inputs change; Trf entered the cycle after iDstCmdReady rises.
REQ-033 iReset pulsed low mid-Trf after 2 of 4 beats -> oDstCmdValid, oDstWriteValid, oGrant go 0 asynchronously; after release a fresh R1 request is granted first only if R0 is idle (priority reset to R0).
